if_id_buffer: RTL

Two-entry elastic buffer between the fetch stage and decode. It captures each fetched instruction together with its incremented PC and fetch error flag, and presents them to decode with a valid/ready handshake. It absorbs decode stalls without dropping instructions, discards wrong-path instructions on a flush, and stops accepting new instructions once a HALT has been accepted.

---
 rtl/if_id_buffer.sv | 110 +++++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// Elastic fetch-to-decode buffer: 2-entry FIFO with IF_ID_SKID_EN, else a 1-entry pipeline register.
// Latency 1 cycle; flush drops all entries; if_ready stays low after a HALT is accepted, until flush or rst.
module if_id_buffer #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [4:0]  HALT_OPC  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [15:0] if_instr,
    input  logic [15:0] if_pc_next,
    input  logic        if_err,
    input  logic        flush,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc_next,
    output logic        id_err,
    output logic        halt_seen
);

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_next;
        logic        err;
    } entry_t;

`ifdef IF_ID_SKID_EN
    localparam logic [1:0] FULL_CNT = 2'd2;
    localparam logic       PTR_STEP = 1'b1;
`else
    // Single-entry mode: pointers never move, so only slot 0 is used.
    localparam logic [1:0] FULL_CNT = 2'd1;
    localparam logic       PTR_STEP = 1'b0;
`endif

    entry_t     mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       halt_q, halt_d;
    logic       accept, pop;
    entry_t     head;

    assign id_valid  = (count_q != 2'd0);
    assign halt_seen = halt_q;

`ifdef IF_ID_SKID_EN
    assign if_ready = (count_q != FULL_CNT) & ~halt_q;
`else
    assign if_ready = ~halt_q & ((count_q == 2'd0) | id_ready);
`endif

    assign accept = if_valid & if_ready;
    assign pop    = id_valid & id_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        halt_d   = halt_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            halt_d   = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q ^ PTR_STEP;
                if (if_instr[15:11] == HALT_OPC) begin
                    halt_d = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q ^ PTR_STEP;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            halt_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            halt_q   <= halt_d;
            if (accept && !flush) begin
                mem_q[wr_ptr_q] <= '{instr: if_instr, pc_next: if_pc_next, err: if_err};
            end
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign id_instr   = id_valid ? head.instr   : NOP_INSTR;
    assign id_pc_next = id_valid ? head.pc_next : 16'h0000;
    assign id_err     = id_valid ? head.err     : 1'b0;

endmodule
